// File: rtl/usb_rx_buffer_arbiter_if.sv
// Request/grant and status bundle between the USB RX packet buffer arbiter and its requesters.
// Carries almost_full only when USB_RX_BUF_WATERMARK_EN is defined.
interface usb_rx_buffer_arbiter_if #(
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          flush;
  logic          rx_store;
  logic [7:0]    rx_data;
  logic          tx_req;
  logic          tx_gnt;
  logic          hw_req;
  logic [7:0]    hw_data;
  logic          hw_gnt;
  logic          hr_req;
  logic          hr_gnt;
  logic [7:0]    rd_data;
  logic          tx_valid;
  logic          hr_valid;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
`ifdef USB_RX_BUF_WATERMARK_EN
  logic          almost_full;
`endif

  // Requester side: drives strobes and requests, observes grants and status.
  modport master (
`ifdef USB_RX_BUF_WATERMARK_EN
    input  almost_full,
`endif
    output flush, rx_store, rx_data, tx_req, hw_req, hw_data, hr_req,
    input  tx_gnt, hw_gnt, hr_gnt, rd_data, tx_valid, hr_valid,
    input  count, empty, full, overflow
  );

  // Arbiter side.
  modport slave (
`ifdef USB_RX_BUF_WATERMARK_EN
    output almost_full,
`endif
    input  flush, rx_store, rx_data, tx_req, hw_req, hw_data, hr_req,
    output tx_gnt, hw_gnt, hr_gnt, rd_data, tx_valid, hr_valid,
    output count, empty, full, overflow
  );
endinterface

// File: rtl/usb_rx_buffer_arbiter.sv
// Single-ported USB RX packet buffer: RX store has absolute priority, TX/host-write/host-read share
// the remaining slot round-robin. Optional watermark (almost_full, WMARK) under USB_RX_BUF_WATERMARK_EN.
module usb_rx_buffer_arbiter #(
  parameter int unsigned DEPTH = 64
`ifdef USB_RX_BUF_WATERMARK_EN
  , parameter int unsigned WMARK = 48
`endif
) (
  input logic                    clk,
  input logic                    n_rst,
  usb_rx_buffer_arbiter_if.slave bus
);
  // DEPTH must be a power of two (>= 4) so pointers wrap for free.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    RR_TX = 2'd0,
    RR_HW = 2'd1,
    RR_HR = 2'd2
  } rr_e;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          empty_q;
  logic          full_q;
  logic          overflow_q;
  logic [7:0]    rd_data_q;
  logic          tx_valid_q;
  logic          hr_valid_q;
  rr_e           rr_q;
`ifdef USB_RX_BUF_WATERMARK_EN
  logic          almost_full_q;
`endif

  logic          elig_tx;
  logic          elig_hw;
  logic          elig_hr;
  logic          hw_block;
  logic          tx_gnt_c;
  logic          hw_gnt_c;
  logic          hr_gnt_c;
  rr_e           rr_next;
  logic          rx_wr;
  logic          wr_en;
  logic          rd_en;
  logic [7:0]    wr_data;
  logic [CW-1:0] count_next;

`ifdef USB_RX_BUF_WATERMARK_EN
  assign hw_block = almost_full_q;
`else
  assign hw_block = 1'b0;
`endif

  // Grant selection: flush and RX store pre-empt the round-robin slot entirely.
  always_comb begin
    tx_gnt_c = 1'b0;
    hw_gnt_c = 1'b0;
    hr_gnt_c = 1'b0;
    rr_next  = rr_q;
    elig_tx  = bus.tx_req && !empty_q;
    elig_hw  = bus.hw_req && !full_q && !hw_block;
    elig_hr  = bus.hr_req && !empty_q;
    if (!bus.flush && !bus.rx_store) begin
      case (rr_q)
        RR_HW: begin
          if (elig_hw)      hw_gnt_c = 1'b1;
          else if (elig_hr) hr_gnt_c = 1'b1;
          else if (elig_tx) tx_gnt_c = 1'b1;
        end
        RR_HR: begin
          if (elig_hr)      hr_gnt_c = 1'b1;
          else if (elig_tx) tx_gnt_c = 1'b1;
          else if (elig_hw) hw_gnt_c = 1'b1;
        end
        default: begin
          if (elig_tx)      tx_gnt_c = 1'b1;
          else if (elig_hw) hw_gnt_c = 1'b1;
          else if (elig_hr) hr_gnt_c = 1'b1;
        end
      endcase
    end
    if (tx_gnt_c)      rr_next = RR_HW;
    else if (hw_gnt_c) rr_next = RR_HR;
    else if (hr_gnt_c) rr_next = RR_TX;
  end

  // Access decode; at most one of wr_en / rd_en is ever set.
  always_comb begin
    rx_wr   = bus.rx_store && !bus.flush && !full_q;
    wr_en   = rx_wr || hw_gnt_c;
    rd_en   = tx_gnt_c || hr_gnt_c;
    wr_data = hw_gnt_c ? bus.hw_data : bus.rx_data;
    if (bus.flush)  count_next = '0;
    else if (wr_en) count_next = count_q + CW'(1);
    else if (rd_en) count_next = count_q - CW'(1);
    else            count_next = count_q;
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      rd_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      hr_valid_q    <= 1'b0;
      rr_q          <= RR_TX;
`ifdef USB_RX_BUF_WATERMARK_EN
      almost_full_q <= 1'b0;
`endif
    end else begin
      tx_valid_q <= tx_gnt_c;
      hr_valid_q <= hr_gnt_c;
      rr_q       <= rr_next;
      count_q    <= count_next;
      empty_q    <= (count_next == '0);
      full_q     <= (count_next == CW'(DEPTH));
`ifdef USB_RX_BUF_WATERMARK_EN
      almost_full_q <= (count_next >= CW'(WMARK));
`endif
      if (rd_en) rd_data_q <= mem[rd_ptr];
      if (bus.flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (rd_en) rd_ptr <= rd_ptr + AW'(1);
        if (bus.rx_store && full_q) overflow_q <= 1'b1;
      end
    end
  end

  assign bus.tx_gnt   = tx_gnt_c;
  assign bus.hw_gnt   = hw_gnt_c;
  assign bus.hr_gnt   = hr_gnt_c;
  assign bus.rd_data  = rd_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.hr_valid = hr_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
`ifdef USB_RX_BUF_WATERMARK_EN
  assign bus.almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_usb_rx_buffer_arbiter.sv
// Scoreboard bench for usb_rx_buffer_arbiter: expected read bytes are queued at grant time and
// checked by a monitor when tx_valid/hr_valid pulse; grants and status are checked directly.
module tb_usb_rx_buffer_arbiter;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_rx_buffer_arbiter_if #(.DEPTH(DEPTH)) bus ();
  usb_rx_buffer_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  typedef struct packed {
    logic       src;   // 0 = TX, 1 = host read
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl[$];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_read(input logic src);
    exp_t e;
    e.src  = src;
    e.data = mdl.pop_front();
    exp_q.push_back(e);
  endtask

  task automatic rx_push(input logic [7:0] b);
    bus.rx_store = 1'b1;
    bus.rx_data  = b;
    if (mdl.size() < DEPTH) mdl.push_back(b);
    cyc();
    bus.rx_store = 1'b0;
  endtask

  task automatic gnt_chk(input string name, input logic [2:0] req);
    #1;
    chk(name, {29'd0, bus.tx_gnt, bus.hw_gnt, bus.hr_gnt}, {29'd0, req});
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.tx_valid || bus.hr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {30'd0, bus.tx_valid, bus.hr_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_src", {30'd0, bus.tx_valid, bus.hr_valid}, e.src ? 32'd1 : 32'd2);
        chk("rd_data", {24'd0, bus.rd_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst        = 1'b0;
    bus.flush    = 1'b0;
    bus.rx_store = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_req   = 1'b0;
    bus.hw_req   = 1'b0;
    bus.hw_data  = 8'h00;
    bus.hr_req   = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_valids", {30'd0, bus.tx_valid, bus.hr_valid}, 32'd0);
    n_rst = 1'b1;
    cyc();

    // T1: three RX bytes drained by TX
    rx_push(8'hA5);
    rx_push(8'h3C);
    rx_push(8'h01);
    chk("t1_count3", 32'(bus.count), 32'd3);
    bus.tx_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gnt_chk("t1_tx_gnt", 3'b100);
      model_read(1'b0);
      cyc();
    end
    gnt_chk("t1_empty_no_gnt", 3'b000);
    bus.tx_req = 1'b0;
    chk("t1_count0", 32'(bus.count), 32'd0);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    cyc();

    // T2: rx_store pre-empts TX/HW in the same cycle
    rx_push(8'h11);
    bus.rx_store = 1'b1;
    bus.rx_data  = 8'h22;
    bus.tx_req   = 1'b1;
    bus.hw_req   = 1'b1;
    bus.hw_data  = 8'h33;
    mdl.push_back(8'h22);
    gnt_chk("t2_rx_blocks", 3'b000);
    cyc();
    bus.rx_store = 1'b0;
    gnt_chk("t2_hw_next", 3'b010);
    mdl.push_back(8'h33);
    cyc();
    bus.hw_req = 1'b0;
    gnt_chk("t2_tx_next", 3'b100);
    model_read(1'b0);
    cyc();
    bus.tx_req = 1'b0;
    bus.hr_req = 1'b1;
    gnt_chk("t2_hr", 3'b001);
    model_read(1'b1);
    cyc();
    bus.hr_req = 1'b0;
    chk("t2_count", 32'(bus.count), 32'd1);

    // T3: three-way rotation at count 8
    for (int i = 0; i < 7; i++) rx_push(8'(8'h40 + i));
    chk("t3_count8", 32'(bus.count), 32'd8);
    bus.tx_req = 1'b1;
    bus.hw_req = 1'b1;
    bus.hr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] eg;
      eg = 3'b100 >> (i % 3);
      bus.hw_data = 8'(8'h80 + i);
      gnt_chk("t3_rotate", eg);
      if (i % 3 == 0)      model_read(1'b0);
      else if (i % 3 == 1) mdl.push_back(bus.hw_data);
      else                 model_read(1'b1);
      cyc();
      if (i == 2) chk("t3_count_triple1", 32'(bus.count), 32'd7);
      if (i == 5) chk("t3_count_triple2", 32'(bus.count), 32'd6);
    end
    bus.hw_req = 1'b0;
    bus.hr_req = 1'b0;
    while (mdl.size() > 0) begin
      gnt_chk("t3_drain", 3'b100);
      model_read(1'b0);
      cyc();
    end
    bus.tx_req = 1'b0;
    chk("t3_drained", 32'(bus.empty), 32'd1);

    // T4: fill to DEPTH, overflow on one more store
    for (int i = 0; i < DEPTH; i++) rx_push(8'(i * 3 + 7));
    chk("t4_count_full", 32'(bus.count), 32'd64);
    chk("t4_full", 32'(bus.full), 32'd1);
    chk("t4_no_ovf_yet", 32'(bus.overflow), 32'd0);
    rx_push(8'hEE);
    chk("t4_count_still", 32'(bus.count), 32'd64);
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    bus.hw_req = 1'b1;
    bus.tx_req = 1'b1;
    gnt_chk("t4_hw_blocked_full", 3'b100);
    model_read(1'b0);
    cyc();
    bus.hw_req = 1'b0;
    bus.tx_req = 1'b0;
    chk("t4_count63", 32'(bus.count), 32'd63);
    chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

    // T5: flush at count 10, then pointer wrap over 3xDEPTH
    bus.hr_req = 1'b1;
    for (int i = 0; i < 53; i++) begin
      gnt_chk("t5_hr_drain", 3'b001);
      model_read(1'b1);
      cyc();
    end
    bus.hr_req = 1'b0;
    chk("t5_count10", 32'(bus.count), 32'd10);
    chk("t5_ovf_before", 32'(bus.overflow), 32'd1);
    bus.flush  = 1'b1;
    bus.tx_req = 1'b1;
    gnt_chk("t5_flush_no_gnt", 3'b000);
    cyc();
    bus.flush  = 1'b0;
    bus.tx_req = 1'b0;
    mdl.delete();
    chk("t5_flush_count", 32'(bus.count), 32'd0);
    chk("t5_flush_empty", 32'(bus.empty), 32'd1);
    chk("t5_flush_ovf", 32'(bus.overflow), 32'd0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 48; k++) rx_push(8'((r * 48 + k) ^ 8'h96));
      bus.hr_req = 1'b1;
      while (mdl.size() > 0) begin
        gnt_chk("t5_wrap_rd", 3'b001);
        model_read(1'b1);
        cyc();
      end
      bus.hr_req = 1'b0;
    end
    chk("t5_wrap_empty", 32'(bus.count), 32'd0);

    // T6: reset while a tx_valid is pending
    rx_push(8'h5C);
    rx_push(8'hC5);
    bus.tx_req = 1'b1;
    gnt_chk("t6_gnt", 3'b100);
    cyc();
    chk("t6_valid_pending", 32'(bus.tx_valid), 32'd1);
    n_rst = 1'b0;
    mdl.delete();
    #1;
    chk("t6_rst_valids", {30'd0, bus.tx_valid, bus.hr_valid}, 32'd0);
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_flags", {29'd0, bus.empty, bus.full, bus.overflow}, 32'd4);
    chk("t6_rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("t6_rst_gnt", {29'd0, bus.tx_gnt, bus.hw_gnt, bus.hr_gnt}, 32'd0);
    cyc();
    cyc();
    bus.tx_req = 1'b0;
    n_rst = 1'b1;
    cyc();

`ifdef USB_RX_BUF_WATERMARK_EN
    // T7: watermark reserves space for RX
    chk("t7_af_reset", 32'(bus.almost_full), 32'd0);
    for (int i = 0; i < 47; i++) rx_push(8'(i));
    chk("t7_af_47", 32'(bus.almost_full), 32'd0);
    rx_push(8'hAB);
    chk("t7_count48", 32'(bus.count), 32'd48);
    chk("t7_af_48", 32'(bus.almost_full), 32'd1);
    bus.hw_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gnt_chk("t7_hw_blocked", 3'b000);
      cyc();
    end
    bus.hw_req = 1'b0;
    bus.hr_req = 1'b1;
    gnt_chk("t7_hr", 3'b001);
    model_read(1'b1);
    cyc();
    bus.hr_req = 1'b0;
    chk("t7_af_47_again", 32'(bus.almost_full), 32'd0);
`endif

    repeat (3) cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
